alu_mc: RTL
===========

# alu_mc

Multi-cycle, width-parametrised successor to the picoMIPS single-cycle ALU. It keeps the four core functions (pass A, pass B, add, subtract) with V/N/Z/C flags and adds an unsigned N×N→2N multiply built on an iterative shift-add datapath. It sits between the register file and the write-back path, with a start/ready/done handshake that lets the controller stall during multiply. All outputs are registered.

## Interface
- `N`, default 8: operand and result width; minimum 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only on an edge where `ready`=1.
- `func`  in  3  function code, from the package enum.
- `a`, `b`  in  N  operands, sampled with `start`.
- `ready`  out  1  high when a new request can be accepted.
- `done`  out  1  one-cycle pulse; `result`, `result_hi` and `flags` are valid from this cycle on.
- `result`  out  N  low half of the result.
- `result_hi`  out  N  high half of the product; 0 for non-MUL operations.
- `flags`  out  4  {V,N,Z,C}.

## Operation
- Function codes: RA=000, RB=001, RADD=010, RSUB=011, RMUL=100. Codes 101–111 are reserved and behave as RA.
- FSM states: IDLE and MUL.
  - IDLE: `ready`=1.
  - `start` with a non-MUL code: compute and register the result and flags, pulse `done`, and stay in IDLE.
  - `start` with RMUL: latch the multiplicand and multiplier, clear the accumulator, load the iteration counter with N-1, and go to MUL.
- MUL: `ready`=0.
  - Each edge: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator, with carry-out kept.
  - Then shift the accumulator right by 1 and decrement the counter.
  - On the edge where the counter reaches 0: register the product and flags, pulse `done`, and return to IDLE.
- Arithmetic rules:
  - RADD: result = (a+b) mod 2^N.
  - RSUB: result = (a−b) mod 2^N, computed as a + ~b + 1.
- Flag rules. V and C are computed on bit N-1; Z and N are computed on the N-bit `result`.
  - RADD: V = signed overflow; C = carry-out.
  - RSUB: V = signed overflow; C = borrow, i.e. 1 when a < b unsigned.
  - RA/RB: V = 0 and C = 0.
  - RMUL: V = (`result_hi` ≠ 0); C = 0; Z = full 2N product == 0; N = 0.
  - All other operations: Z = (`result` == 0) and N = `result`[N-1].
- Registered outputs hold their value until the next completed operation. `done` is the only pulse.
- `start` while `ready`=0 is ignored; no queueing.
- Reset, including reset mid-multiply, takes effect immediately and asynchronously:
  - state = IDLE;
  - `result`, `result_hi`, `flags`, `done`, accumulator and counter all = 0;
  - `ready` = 1.
  - No `done` is issued for an aborted multiply.

## Timing
- Non-MUL: request sampled at edge k; `done`=1 and outputs valid during cycle k→k+1. Latency is 1 edge; sustained throughput is 1 per cycle.
- MUL: request sampled at edge k. `ready`=0 from after edge k until edge k+N. `done`=1 and the product is valid after edge k+N, so latency is N edges.
- `ready` returns to 1 in the same cycle `done` pulses. A `start` in that cycle is accepted, which makes MUL→MUL back-to-back possible with no bubble.
- `a`, `b` and `func` may change freely after the sampling edge; the operation uses latched copies.

## Structure
- Package `alu_mc_pkg` holds:
  - typedef enum logic [2:0] `alu_func_t` with the codes above;
  - typedef enum logic `alu_state_t` {IDLE, MUL};
  - flag index constants `FLAG_V`=3, `FLAG_N`=2, `FLAG_Z`=1, `FLAG_C`=0.
- Sub-module `alu_mc_mul`: the shift-add iterator, containing the accumulator, counter and carry. Its interface is load / step / last.
- The top level holds:
  - the FSM;
  - the combinational add/sub with flag logic, a direct generalisation of the single-cycle ALU to width N;
  - the output registers.

## Test plan
- Reset: assert `nReset`=0 asynchronously mid-cycle → all outputs 0, `ready`=1 immediately. Release, then RADD a=8'h7F b=8'h01 → next cycle `result`=8'h80, flags V=1 N=1 Z=0 C=0, `done` pulse width 1.
- RSUB, N=8: a=8'h00 b=8'h01 → `result`=8'hFF, C=1 (borrow), N=1. Then a=8'h05 b=8'h05 → `result`=0, Z=1, C=0.
- RMUL: a=8'hFF b=8'hFF → `done` exactly 8 edges after sampling, `result_hi`=8'hFE, `result`=8'h01, V=1. Check that `ready`=0 throughout and that a `start` during MUL is ignored.
- RMUL a=8'h00 b=8'h37 → product 0, Z=1. Then back-to-back RMUL a=3 b=5 issued in the `done` cycle → `result`=8'h0F, `result_hi`=0, V=0, 8 edges later.
- Reset asserted 4 edges into RMUL → no `done`; next RADD 1+1 returns 2 after 1 edge.
- Parameter sweep N=4 and N=16, random operands vs a reference model. Include reserved codes 101–111 → RA behaviour.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_pkg
// Shared types and constants for the multi-cycle ALU (alu_mc).
//   alu_func_t  : 3-bit function code (RA, RB, RADD, RSUB, RMUL; 101-111 act as RA)
//   alu_state_t : controller state (IDLE, MUL)
//   FLAG_*      : bit positions of {V,N,Z,C} inside the 4-bit flags word
//   pack_flags  : assembles a flags word from individual flag bits
// -----------------------------------------------------------------------------
package alu_mc_pkg;

  typedef enum logic [2:0] {
    RA   = 3'b000,
    RB   = 3'b001,
    RADD = 3'b010,
    RSUB = 3'b011,
    RMUL = 3'b100
  } alu_func_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                            input logic z, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// -----------------------------------------------------------------------------
// alu_mc_mul
// Iterative shift-add unsigned multiplier, one partial product per clock.
//   clk, nReset     : clock, asynchronous active-low reset
//   i_load          : latch multiplicand/multiplier, clear accumulator,
//                     load the iteration counter with N-1
//   i_step          : perform one add-and-shift iteration
//   i_mcand         : multiplicand (N bits)
//   i_mplier        : multiplier (N bits)
//   o_last          : counter is 0, so the coming step is the final one
//   o_product_next  : accumulator value after the coming step; on the final
//                     step this is the full 2N-bit product, letting the
//                     controller register it on the same edge
// -----------------------------------------------------------------------------
module alu_mc_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [N-1:0]   i_mcand,
  input  logic [N-1:0]   i_mplier,
  output logic           o_last,
  output logic [2*N-1:0] o_product_next
);

  localparam int CW = $clog2(N);

  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_count;

  // Upper half plus multiplicand, one bit wider so the carry-out survives
  // and becomes the new MSB after the right shift.
  logic [N:0]     w_upper;
  logic [2*N-1:0] w_acc_next;

  assign w_upper    = r_mplier[0] ? ({1'b0, r_acc[2*N-1:N]} + {1'b0, r_mcand})
                                  : {1'b0, r_acc[2*N-1:N]};
  assign w_acc_next = {w_upper, r_acc[N-1:1]};

  assign o_last         = (r_count == '0);
  assign o_product_next = w_acc_next;

  // NOTE: state registers use non-blocking assignments and every one of them,
  // operand latches included, has an explicit reset value so that an aborted
  // multiply leaves nothing stale behind.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_count  <= CW'(N - 1);
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU: pass A, pass B, add, subtract (single edge) and unsigned
// N x N -> 2N multiply (N edges) with a start/ready/done handshake.
// N must be at least 4.
//   clk        : system clock, rising edge
//   nReset     : asynchronous active-low reset
//   start      : request, taken only while ready = 1
//   func       : function code (alu_func_t); 101-111 behave as RA
//   a, b       : operands, sampled with start
//   ready      : new request can be accepted
//   done       : one-cycle pulse, outputs valid from this cycle on
//   result     : low half of the result
//   result_hi  : high half of the product, 0 for non-multiply operations
//   flags      : {V,N,Z,C}
// -----------------------------------------------------------------------------
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [2:0]   func,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic [3:0]   flags
);

  alu_state_t     r_state;
  logic           r_ready;
  logic           r_done;
  logic [N-1:0]   r_result;
  logic [N-1:0]   r_result_hi;
  logic [3:0]     r_flags;

  alu_func_t      w_func;
  logic           w_accept;
  logic           w_load;
  logic           w_step;
  logic           w_last;
  logic [2*N-1:0] w_product;
  logic [3:0]     w_mul_flags;

  logic           w_is_sub;
  logic [N-1:0]   w_b_eff;
  logic [N:0]     w_sum;
  logic           w_ovf;
  logic [N-1:0]   w_alu_result;
  logic           w_alu_v;
  logic           w_alu_c;
  logic [3:0]     w_alu_flags;

  assign w_func   = alu_func_t'(func);
  assign w_accept = (r_state == IDLE) && start;
  assign w_load   = w_accept && (w_func == RMUL);
  assign w_step   = (r_state == MUL);

  // ---------------------------------------------------------------------------
  // Single-edge datapath: subtract is a + ~b + 1 sharing the adder.
  // ---------------------------------------------------------------------------
  assign w_is_sub = (w_func == RSUB);
  assign w_b_eff  = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_is_sub};
  // Signed overflow: both adder inputs share a sign the sum does not.
  assign w_ovf    = (a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != a[N-1]);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_alu_result = a;
    w_alu_v      = 1'b0;
    w_alu_c      = 1'b0;
    case (w_func)
      RB: w_alu_result = b;
      RADD: begin
        w_alu_result = w_sum[N-1:0];
        w_alu_v      = w_ovf;
        w_alu_c      = w_sum[N];
      end
      RSUB: begin
        w_alu_result = w_sum[N-1:0];
        w_alu_v      = w_ovf;
        // Carry-out of a + ~b + 1 is "no borrow"; report the borrow.
        w_alu_c      = ~w_sum[N];
      end
      default: w_alu_result = a;
    endcase
  end

  assign w_alu_flags = pack_flags(w_alu_v, w_alu_result[N-1],
                                  (w_alu_result == '0), w_alu_c);

  // ---------------------------------------------------------------------------
  // Multiply iterator
  // ---------------------------------------------------------------------------
  alu_mc_mul #(.N(N)) u_mul (
    .clk            (clk),
    .nReset         (nReset),
    .i_load         (w_load),
    .i_step         (w_step),
    .i_mcand        (a),
    .i_mplier       (b),
    .o_last         (w_last),
    .o_product_next (w_product)
  );

  assign w_mul_flags = pack_flags(|w_product[2*N-1:N], 1'b0,
                                  (w_product == '0), 1'b0);

  // ---------------------------------------------------------------------------
  // Controller and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_func == RMUL) begin
              r_state <= MUL;
              r_ready <= 1'b0;
            end else begin
              r_result    <= w_alu_result;
              r_result_hi <= '0;
              r_flags     <= w_alu_flags;
              r_done      <= 1'b1;
            end
          end
        end
        MUL: begin
          if (w_last) begin
            r_result    <= w_product[N-1:0];
            r_result_hi <= w_product[2*N-1:N];
            r_flags     <= w_mul_flags;
            r_done      <= 1'b1;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flags     = r_flags;

endmodule
